// File: rtl/dma_pkg.sv
// dma_pkg: descriptor layout, completion-record fields and FSM encodings shared by the DMA descriptor engines.
package dma_pkg;
  localparam int DESC_NEXT_PTR_WORD = 4;
  localparam int DESC_BYTES_WORD = 6;
  localparam int DESC_CTRL_WORD = 7;
  localparam int DMA_OWNED_BIT = 31;
  localparam int DMA_IRQ_EN_BIT = 14;
  localparam int DMA_RUN_BIT = 5;
  localparam int W7_ERR_LSB = 16;
  localparam int REC_W = 104;
  localparam int REC_ERR_LSB = 96;
  localparam int REC_ADDR_LSB = 64;
  localparam int REC_W7_LSB = 32;
  localparam int REC_BYTES_LSB = 0;
  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_BEAT0 = 2'd1,
    WB_BEAT1 = 2'd2,
    WB_DONE = 2'd3
  } wb_state_e;
endpackage

// File: rtl/dma_desc_writeback.sv
// dma_desc_writeback: pops completion records and writes back byte count and control/status words as a 2-beat burst.
module dma_desc_writeback
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OWNED_BIT = DMA_OWNED_BIT,
  parameter int IRQ_EN_BIT = DMA_IRQ_EN_BIT,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       csr_control_i,
  input  logic              wb_fifo_empty_i,
  input  logic [REC_W-1:0]  wb_fifo_rddata_i,
  output logic              wb_fifo_rd_o,
  output logic              dma_desc_wb_write_o,
  output logic [ADDR_W-1:0] dma_desc_wb_addr_o,
  output logic [3:0]        dma_desc_wb_bcount_o,
  output logic [31:0]       dma_desc_wb_wrdata_o,
  output logic [3:0]        dma_desc_wb_byteen_o,
  input  logic              dma_desc_wb_waitrequest_i,
  output logic              dma_desc_wb_irq_o,
  output logic [CNT_W-1:0]  dma_desc_wb_count_o,
  output logic              dma_desc_wb_busy_o
);
  wb_state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] bytes_q, w7_q, w7_d;
  logic irq_en_q;
  logic [CNT_W-1:0] count_q;
  logic unused_ctrl;
  assign unused_ctrl = ^csr_control_i;
  always_comb begin
    state_d = state_q;
    wb_fifo_rd_o = 1'b0;
    w7_d = wb_fifo_rddata_i[REC_W7_LSB +: 32];
    w7_d[W7_ERR_LSB +: 8] = wb_fifo_rddata_i[REC_ERR_LSB +: 8];
    w7_d[OWNED_BIT] = 1'b0;
    case (state_q)
      WB_IDLE: begin
        wb_fifo_rd_o = csr_control_i[DMA_RUN_BIT] && !wb_fifo_empty_i;
        state_d = wb_fifo_rd_o ? WB_BEAT0 : WB_IDLE;
      end
      WB_BEAT0: state_d = dma_desc_wb_waitrequest_i ? WB_BEAT0 : WB_BEAT1;
      WB_BEAT1: state_d = dma_desc_wb_waitrequest_i ? WB_BEAT1 : WB_DONE;
      WB_DONE:  state_d = WB_IDLE;
      default:  state_d = WB_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WB_IDLE;
      addr_q <= '0;
      bytes_q <= '0;
      w7_q <= '0;
      irq_en_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (wb_fifo_rd_o) begin
        addr_q <= ADDR_W'(wb_fifo_rddata_i[REC_ADDR_LSB +: 32]) + ADDR_W'(DESC_BYTES_WORD * 4);
        bytes_q <= wb_fifo_rddata_i[REC_BYTES_LSB +: 32];
        w7_q <= w7_d;
        irq_en_q <= wb_fifo_rddata_i[REC_W7_LSB + IRQ_EN_BIT];
      end
      if (state_q == WB_DONE) count_q <= count_q + 1'b1;
    end
  end
  assign dma_desc_wb_write_o = state_q == WB_BEAT0 || state_q == WB_BEAT1;
  assign dma_desc_wb_addr_o = addr_q;
  assign dma_desc_wb_bcount_o = 4'h2;
  assign dma_desc_wb_byteen_o = 4'hF;
  assign dma_desc_wb_wrdata_o = state_q == WB_BEAT1 ? w7_q : state_q == WB_BEAT0 ? bytes_q : 32'h0;
  assign dma_desc_wb_irq_o = state_q == WB_DONE && irq_en_q;
  assign dma_desc_wb_count_o = count_q;
  assign dma_desc_wb_busy_o = state_q != WB_IDLE;
endmodule

// File: tb/tb_dma_desc_writeback.sv
// tb_dma_desc_writeback: directed write-back scenarios against a queue-based completion FIFO model.
module tb_dma_desc_writeback;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] csr = 32'h0;
  logic fifo_empty = 1'b1;
  logic [103:0] fifo_data = '0;
  logic fifo_rd, wr, irq, busy;
  logic waitreq = 1'b0;
  logic [31:0] addr, wrdata;
  logic [3:0] bcount, byteen;
  logic [1:0] count;
  logic [103:0] q[$];
  logic [63:0] beats[$];
  int pops = 0, irqs = 0, vecs = 0, errs = 0;

  dma_desc_writeback #(.CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .csr_control_i(csr),
    .wb_fifo_empty_i(fifo_empty), .wb_fifo_rddata_i(fifo_data), .wb_fifo_rd_o(fifo_rd),
    .dma_desc_wb_write_o(wr), .dma_desc_wb_addr_o(addr), .dma_desc_wb_bcount_o(bcount),
    .dma_desc_wb_wrdata_o(wrdata), .dma_desc_wb_byteen_o(byteen),
    .dma_desc_wb_waitrequest_i(waitreq), .dma_desc_wb_irq_o(irq),
    .dma_desc_wb_count_o(count), .dma_desc_wb_busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (fifo_rd && q.size() > 0) begin
      void'(q.pop_front());
      fifo_empty <= q.size() == 0;
      fifo_data <= q.size() > 0 ? q[0] : '0;
    end

  always @(negedge clk) begin
    if (fifo_rd) pops++;
    if (irq) irqs++;
    if (wr && !waitreq) beats.push_back({addr, wrdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] err, input logic [31:0] a, input logic [31:0] w7, input logic [31:0] b);
    q.push_back({err, a, w7, b});
    fifo_empty <= 1'b0;
    fifo_data <= q[0];
  endtask

  task automatic clr();
    beats.delete();
    pops = 0;
    irqs = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      tick(1);
      n++;
    end while ((busy || (!fifo_empty && csr[5])) && n < 200);
    check("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  function automatic logic [63:0] beat(input int i);
    return i < beats.size() ? beats[i] : 64'hDEAD;
  endfunction

  initial begin
    tick(2);
    check("rst_write", {63'd0, wr}, 0);
    check("rst_rd", {63'd0, fifo_rd}, 0);
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_count", {62'd0, count}, 0);
    check("rst_addr_data", {addr, wrdata}, 0);
    reset_n = 1'b1;
    tick(1);
    clr();
    push(8'h00, 32'h1000, 32'h8000_4001, 32'h200);
    csr = 32'h20;
    wait_idle();
    check("t1_beats", beats.size(), 2);
    check("t1_beat0", beat(0), {32'h1018, 32'h200});
    check("t1_beat1", beat(1), {32'h1018, 32'h0000_4001});
    check("t1_irq", irqs, 1);
    check("t1_pops", pops, 1);
    check("t1_count", {62'd0, count}, 1);
    check("t1_const", {56'd0, bcount, byteen}, 64'h2F);

    clr();
    waitreq = 1'b1;
    push(8'h00, 32'h1000, 32'h8000_4001, 32'h200);
    tick(1);
    check("t2_b0_a", {31'd0, wr, addr}, {31'd0, 1'b1, 32'h1018});
    check("t2_b0_d", wrdata, 32'h200);
    tick(2);
    check("t2_b0_hold", {31'd0, wr, addr, wrdata}, {31'd0, 1'b1, 32'h1018, 32'h200});
    waitreq = 1'b0;
    tick(1);
    waitreq = 1'b1;
    check("t2_b1", {31'd0, wr, addr, wrdata}, {31'd0, 1'b1, 32'h1018, 32'h4001});
    tick(3);
    check("t2_b1_hold", {31'd0, wr, addr, wrdata}, {31'd0, 1'b1, 32'h1018, 32'h4001});
    check("t2_busy", {63'd0, busy}, 1);
    waitreq = 1'b0;
    wait_idle();
    check("t2_beats", beats.size(), 2);
    check("t2_beat0", beat(0), {32'h1018, 32'h200});
    check("t2_beat1", beat(1), {32'h1018, 32'h4001});
    check("t2_pops", pops, 1);
    check("t2_irq", irqs, 1);
    check("t2_count", {62'd0, count}, 2);

    clr();
    push(8'h5A, 32'h2000, 32'h8000_0000, 32'h10);
    wait_idle();
    check("t3_beat0", beat(0), {32'h2018, 32'h10});
    check("t3_beat1", beat(1), {32'h2018, 32'h005A_0000});
    check("t3_irq", irqs, 0);
    check("t3_count", {62'd0, count}, 3);

    clr();
    push(8'h00, 32'h3000, 32'h8000_4000, 32'h1);
    push(8'h00, 32'h3100, 32'h8000_4000, 32'h2);
    push(8'h00, 32'h3200, 32'h8000_4000, 32'h3);
    tick(1);
    csr = 32'h0;
    wait_idle();
    check("t4_rec1_beats", beats.size(), 2);
    check("t4_rec1_b1", beat(1), {32'h3018, 32'h4000});
    check("t4_count_wrap", {62'd0, count}, 0);
    tick(5);
    check("t4_no_pop", pops, 1);
    check("t4_idle", {63'd0, busy}, 0);
    csr = 32'h20;
    wait_idle();
    check("t4_pops", pops, 3);
    check("t4_irqs", irqs, 3);
    check("t4_beat5", beat(5), {32'h3218, 32'h4000});
    check("t4_count", {62'd0, count}, 2);

    clr();
    push(8'h00, 32'h4000, 32'h8000_4000, 32'h8);
    tick(2);
    waitreq = 1'b1;
    tick(1);
    check("t5_in_b1", {63'd0, wr}, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_wr", {63'd0, wr}, 0);
    check("t5_rst_busy", {63'd0, busy}, 0);
    check("t5_rst_count", {62'd0, count}, 0);
    check("t5_rst_data", wrdata, 0);
    csr = 32'h0;
    waitreq = 1'b0;
    push(8'h00, 32'hFFFF_FFF0, 32'h0000_0003, 32'h4);
    tick(2);
    reset_n = 1'b1;
    clr();
    tick(3);
    check("t5_no_pop", pops, 0);
    csr = 32'h20;
    wait_idle();
    check("t5_pops", pops, 1);
    check("t5_wrap_b0", beat(0), {32'h0000_0008, 32'h4});
    check("t5_wrap_b1", beat(1), {32'h0000_0008, 32'h3});
    check("t5_irq", irqs, 0);
    check("t5_count", {62'd0, count}, 1);

    push(8'h00, 32'h5000, 32'h0, 32'h1);
    push(8'h00, 32'h5100, 32'h0, 32'h1);
    wait_idle();
    check("t6_count3", {62'd0, count}, 3);
    push(8'h00, 32'h5200, 32'h0, 32'h1);
    wait_idle();
    check("t6_wrap0", {62'd0, count}, 0);
    push(8'h00, 32'h5300, 32'h0, 32'h1);
    wait_idle();
    check("t6_after1", {62'd0, count}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
